muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  - Iterative M-extension unit sitting directly downstream of the execute stage.
//  - Consumes the execute-stage ALU operands and M-op code; computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//  - Stalls the pipeline while busy and returns one XLEN result to the LSU-side result mux.
// PARAMETERS
//  - XLEN  32  datapath width; iteration counter is $clog2(XLEN) bits.
// PORTS
//  - clk          in   1     clock; single clock domain, rising edge.
//  - rst_n        in   1     reset; asynchronous, active-low.
//  - req_i        in   1     execute stage presents a valid M-extension op this cycle.
//  - m_ops_i      in   3     op code = funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
//  - operand_1_i  in   XLEN  rs1 value (post-forwarding).
//  - operand_2_i  in   XLEN  rs2 value (post-forwarding).
//  - kill_i       in   1     pipeline flush; aborts the op in flight.
//  - stall_o      out  1     hold the execute stage and everything upstream of it.
//  - done_o       out  1     one-cycle pulse: result_o is valid.
//  - result_o     out  XLEN  result; held until the next accepted request.
// BEHAVIOUR
//  - Reset: state=IDLE; stall_o=0, done_o=0, result_o=0; all internal registers=0.
//  - States: IDLE, CALC, SIGN, DONE.
//  - Acceptance: in IDLE, req_i=1 and kill_i=0 -> request accepted. Call this cycle N.
//    - Latch |op1| and |op2| (signed per op); record result sign; counter=XLEN-1.
//    - req_i while not IDLE is ignored; the pipeline is stalled, so the op is not lost.
//  - stall_o (combinational) = (IDLE & req_i & ~kill_i) | CALC | SIGN. It is 0 in DONE so the pipe advances.
//  - CALC: one iteration per cycle, cycles N+1..N+XLEN; counter decrements; exit to SIGN when counter==0.
//    - Divide: radix-2 restoring; 2*XLEN+1-bit partial remainder; quotient bit = ~borrow.
//    - Multiply: shift-add into a 2*XLEN product register.
//  - SIGN (cycle N+XLEN+1): apply two's-complement negate if needed.
//    - Quotient sign = s1^s2; remainder sign = s1; product sign per MULH/MULHSU rules.
//    - Select low/high half (MUL -> low; MULH* -> high).
//  - DONE (cycle N+XLEN+2): done_o=1, result_o valid; next state IDLE.
//    - A back-to-back request is accepted in the following IDLE cycle.
//  - Early-out: result in DONE at cycle N+1, with no CALC/SIGN.
//    - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> operand_1.
//    - Signed overflow (op1=0x8000_0000, op2=-1): DIV -> 0x8000_0000; REM -> 0.
//  - kill_i=1 in any state: next state IDLE; done_o stays 0; result_o keeps its old value.
//    - kill_i with req_i in IDLE: the request is not accepted.
//  - Reset asserted mid-operation: immediate return to reset values; no done_o.
//  - Arithmetic is modulo 2^XLEN; no exceptions are raised.
// CONFIGURATION
//  - MULDIV_FAST_MUL_EN defined: multiply ops use a single-cycle combinational 2*XLEN multiplier.
//    - Product registered at acceptance; state goes straight to DONE at N+1.
//  - MULDIV_FAST_MUL_EN undefined: multiply uses the iterative CALC/SIGN path with the same latency as divide (done at N+XLEN+2).
//  - Divide is iterative in both configurations.
// TESTING
//  - DIV -7/2 (0xFFFF_FFF9, 2) -> done at N+34, result 0xFFFF_FFFD; REM same operands -> 0xFFFF_FFFF.
//  - DIVU 100/0 -> done at N+1, result 0xFFFF_FFFF; REMU 100/0 -> 100.
//  - DIV 0x8000_0000 / 0xFFFF_FFFF -> done at N+1, result 0x8000_0000; REM -> 0.
//  - MULH 0x8000_0000 * 0x8000_0000 -> 0x4000_0000; MULHU 0xFFFF_FFFF^2 -> 0xFFFF_FFFE.
//    - Latency N+1 with MULDIV_FAST_MUL_EN, N+34 without.
//  - kill_i at cycle N+10 of a DIV -> IDLE at N+11; done_o never pulses; stall_o drops at N+11.
//  - Two back-to-back DIVU ops: stall_o held through each; exactly one done_o pulse per op; second result correct.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU/
//               DIV/DIVU/REM/REMU). Radix-2 restoring divider and shift-add
//               multiplier sharing one accumulator; stalls the pipe while
//               busy and pulses done_o with the result.
//               Optional macro MULDIV_FAST_MUL_EN: multiplies use a single-
//               cycle combinational multiplier instead of the iterative path.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_i,
    input  logic [2:0]      m_ops_i,
    input  logic [XLEN-1:0] operand_1_i,
    input  logic [XLEN-1:0] operand_2_i,
    input  logic            kill_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int              c_cnt_w    = $clog2(XLEN);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(XLEN - 1);

    localparam logic [2:0] c_op_mul    = 3'd0;
    localparam logic [2:0] c_op_mulh   = 3'd1;
    localparam logic [2:0] c_op_mulhsu = 3'd2;
    localparam logic [2:0] c_op_div    = 3'd4;
    localparam logic [2:0] c_op_rem    = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_cnt_w-1:0]   r_cnt;
    // Shared accumulator: {partial remainder, quotient} for divide,
    // product (low 2*XLEN bits) for multiply.
    logic [2*XLEN:0]      r_acc;
    logic [XLEN-1:0]      r_divisor;     // divisor, or multiplicand
    logic [2:0]           r_op;
    logic                 r_neg;
    logic [XLEN-1:0]      r_res_new;     // result of the op in flight
    logic [XLEN-1:0]      r_result;      // last delivered result

    // ------------------------------------------------------------------
    // Request decode and operand conditioning
    // ------------------------------------------------------------------
    logic            w_accept;
    logic            w_is_div;
    logic            w_signed_1;
    logic            w_signed_2;
    logic            w_s1;
    logic            w_s2;
    logic            w_neg;
    logic [XLEN-1:0] w_abs_1;
    logic [XLEN-1:0] w_abs_2;
    logic            w_div_zero;
    logic            w_overflow;
    logic            w_early;
    logic [XLEN-1:0] w_early_res;

    assign w_accept   = (r_state == IDLE) && req_i && !kill_i;
    assign w_is_div   = m_ops_i[2];
    assign w_signed_1 = (m_ops_i == c_op_mulh) || (m_ops_i == c_op_mulhsu) ||
                        (m_ops_i == c_op_div)  || (m_ops_i == c_op_rem);
    assign w_signed_2 = (m_ops_i == c_op_mulh) || (m_ops_i == c_op_div) ||
                        (m_ops_i == c_op_rem);
    assign w_s1       = w_signed_1 && operand_1_i[XLEN-1];
    assign w_s2       = w_signed_2 && operand_2_i[XLEN-1];
    assign w_abs_1    = w_s1 ? (~operand_1_i + 1'b1) : operand_1_i;
    assign w_abs_2    = w_s2 ? (~operand_2_i + 1'b1) : operand_2_i;
    // Remainder follows the dividend sign; quotient and product use s1^s2.
    assign w_neg      = (w_is_div && m_ops_i[1]) ? w_s1 : (w_s1 ^ w_s2);

    assign w_div_zero = w_is_div && (operand_2_i == '0);
    assign w_overflow = w_is_div && !m_ops_i[0] &&
                        (operand_1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                        (operand_2_i == '1);
    assign w_early    = w_div_zero || w_overflow;
    // REM/REMU return the dividend on /0; DIV/DIVU return all ones.
    // Signed overflow: quotient is the dividend (MIN), remainder zero.
    assign w_early_res = w_div_zero ? (m_ops_i[1] ? operand_1_i : '1)
                                    : (m_ops_i[1] ? '0 : operand_1_i);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_prod;
    logic [2*XLEN-1:0] w_fast_signed;
    logic [XLEN-1:0]   w_fast_res;

    assign w_fast_prod   = {{XLEN{1'b0}}, w_abs_1} * {{XLEN{1'b0}}, w_abs_2};
    assign w_fast_signed = w_neg ? (~w_fast_prod + 1'b1) : w_fast_prod;
    assign w_fast_res    = (m_ops_i == c_op_mul) ? w_fast_signed[XLEN-1:0]
                                                 : w_fast_signed[2*XLEN-1:XLEN];
`endif

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [XLEN+1:0] w_trial;
    logic            w_borrow;
    logic [2*XLEN:0] w_div_next;
    logic [XLEN:0]   w_mul_sum;
    logic [2*XLEN:0] w_mul_next;

    // Restoring step: (remainder << 1 | next dividend bit) - divisor.
    assign w_trial    = r_acc[2*XLEN:XLEN-1] - {2'b00, r_divisor};
    assign w_borrow   = w_trial[XLEN+1];
    assign w_div_next = w_borrow ? {r_acc[2*XLEN-1:0], 1'b0}
                                 : {w_trial[XLEN:0], r_acc[XLEN-2:0], 1'b1};

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole product right by one.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                        (r_acc[0] ? {1'b0, r_divisor} : {(XLEN+1){1'b0}});
    assign w_mul_next = {1'b0, w_mul_sum, r_acc[XLEN-1:1]};

    // ------------------------------------------------------------------
    // Sign fix-up and half selection
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   w_div_mag;
    logic [XLEN-1:0]   w_div_res;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_mul_res;
    logic [XLEN-1:0]   w_sign_res;

    assign w_div_mag  = r_op[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
    assign w_div_res  = r_neg ? (~w_div_mag + 1'b1) : w_div_mag;
    assign w_prod_s   = r_neg ? (~r_acc[2*XLEN-1:0] + 1'b1) : r_acc[2*XLEN-1:0];
    assign w_mul_res  = (r_op == c_op_mul) ? w_prod_s[XLEN-1:0]
                                           : w_prod_s[2*XLEN-1:XLEN];
    assign w_sign_res = r_op[2] ? w_div_res : w_mul_res;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a kill in any state returns to IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_early) begin
                        w_state_next = DONE;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!w_is_div) begin
                        w_state_next = DONE;
`endif
                    end else begin
                        w_state_next = CALC;
                    end
                end
            end
            CALC: begin
                if (r_cnt == '0) begin
                    w_state_next = SIGN;
                end
            end
            SIGN:    w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (kill_i) begin
            w_state_next = IDLE;
        end
    end

    assign stall_o  = w_accept || (r_state == CALC) || (r_state == SIGN);
    assign done_o   = (r_state == DONE) && !kill_i;
    assign result_o = done_o ? r_res_new : r_result;

    // Datapath registers: operand capture, iteration, fix-up, result hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_divisor <= '0;
            r_op      <= '0;
            r_neg     <= 1'b0;
            r_res_new <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op      <= m_ops_i;
                        r_neg     <= w_neg;
                        r_cnt     <= c_cnt_init;
                        r_divisor <= w_abs_2;
                        r_acc     <= {{(XLEN+1){1'b0}}, w_abs_1};
                        if (w_early) begin
                            r_res_new <= w_early_res;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!w_is_div) begin
                            r_res_new <= w_fast_res;
`endif
                        end
                    end
                end
                CALC: begin
                    r_acc <= r_op[2] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt - 1'b1;
                end
                SIGN: begin
                    r_res_new <= w_sign_res;
                end
                DONE: begin
                    if (!kill_i) begin
                        r_result <= r_res_new;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
